lfsr4_seq_checker: RTL and testbench

Downstream consumer of the 4-bit maximal-length LFSR generator (recurrence next = {s[2:0], s[3]^s[0]}, seed 4'b1000, period 15). It samples the generator's parallel output, predicts each next value, and acquires and tracks lock. It flags mismatches and the illegal all-zero lock-up state, and keeps a saturating error count. It is the checking half of the built-in pattern-test pair.

---
 rtl/lfsr4_pkg.sv | 18 +
 rtl/lfsr4_predict.sv | 11 +
 rtl/lfsr4_seq_checker.sv | 131 +++++++++++++
 tb/tb_lfsr4_seq_checker.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr4_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator/checker pair:
// checker state encoding, default seed and the sequence recurrence.
package lfsr4_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } fsm_t;

  localparam logic [3:0] SEED_DEFAULT = 4'b1000;

  // Maximal-length recurrence with taps 3 and 0; period 15 from any nonzero value.
  function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[0]};
  endfunction

endpackage

// File: rtl/lfsr4_predict.sv
// Combinational next-value predictor for the 4-bit LFSR sequence.
module lfsr4_predict
  import lfsr4_pkg::*;
(
  input  logic [3:0] cur,
  output logic [3:0] nxt
);

  assign nxt = lfsr4_next(cur);

endmodule

// File: rtl/lfsr4_seq_checker.sv
// Checks a 4-bit LFSR stream: acquires lock, flywheels over isolated errors,
// flags mispredictions and the all-zero lock-up state, counts errors.
module lfsr4_seq_checker
  import lfsr4_pkg::*;
#(
  parameter int         LOCK_CNT = 3,
  parameter int         LOSS_CNT = 2,
  parameter int         ERR_W    = 16,
  parameter logic [3:0] SEED     = SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [3:0]       din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             zero_det,
  output logic             period_mark
);

  fsm_t       fsm, fsm_next;
  logic [3:0] prev, prev_next;
  logic [3:0] match_cnt, match_next;
  logic [3:0] miss_cnt, miss_next;
  logic [3:0] pred;
  logic [3:0] match_inc, miss_inc;
  logic       hit;
  logic       err_hit, zero_hit, period_hit;

  lfsr4_predict u_predict (
    .cur (prev),
    .nxt (pred)
  );

  assign hit       = (din == pred);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!clear) begin
      fsm       <= HUNT;
      prev      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else begin
      fsm       <= fsm_next;
      prev      <= prev_next;
      match_cnt <= match_next;
      miss_cnt  <= miss_next;
    end
  end

  always_comb begin
    fsm_next   = fsm;
    prev_next  = prev;
    match_next = match_cnt;
    miss_next  = miss_cnt;
    if (din_valid) begin
      unique case (fsm)
        HUNT: begin
          if (din != 4'd0) begin
            prev_next  = din;
            match_next = 4'd0;
            fsm_next   = SYNC;
          end
        end
        SYNC: begin
          prev_next = din;
          if (hit) begin
            match_next = match_inc;
            if (match_inc == 4'(LOCK_CNT)) begin
              fsm_next  = LOCKED;
              miss_next = 4'd0;
            end
          end else if (din != 4'd0) begin
            match_next = 4'd0;
          end else begin
            fsm_next = HUNT;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_next = 4'd0;
            prev_next = din;
          end else begin
            // Flywheel on the prediction so one bad sample costs one error.
            miss_next = miss_inc;
            prev_next = pred;
            if (miss_inc == 4'(LOSS_CNT)) fsm_next = HUNT;
          end
        end
        default: fsm_next = HUNT;
      endcase
    end
  end

  always_comb begin
    err_hit    = 1'b0;
    zero_hit   = 1'b0;
    period_hit = 1'b0;
    if (din_valid) begin
      zero_hit = (din == 4'd0);
      if (fsm == LOCKED) begin
        err_hit    = !hit;
        period_hit = hit && (din == SEED);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      zero_det    <= 1'b0;
      period_mark <= 1'b0;
      err_count   <= '0;
    end else begin
      locked      <= (fsm_next == LOCKED);
      err_pulse   <= err_hit;
      zero_det    <= zero_hit;
      period_mark <= period_hit;
      if (err_clr)
        err_count <= err_hit ? ERR_W'(1) : '0;
      else if (err_hit && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_lfsr4_seq_checker.sv
// Directed bench for lfsr4_seq_checker: a default instance plus an ERR_W=2
// instance sharing the same stimulus for counter-saturation checks.
module tb_lfsr4_seq_checker;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  din = 4'd0;
  logic        din_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked, err_pulse, zero_det, period_mark;
  logic [15:0] err_count;
  logic        locked2, err_pulse2, zero_det2, period_mark2;
  logic [1:0]  err_count2;

  int n_cmp  = 0;
  int n_fail = 0;
  int idx    = 0;

  // Generator sequence from seed 1000, hand-expanded.
  logic [3:0] seq [15] = '{4'h8, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4};

  always #5 clk = ~clk;

  lfsr4_seq_checker dut (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .zero_det(zero_det), .period_mark(period_mark)
  );

  lfsr4_seq_checker #(.ERR_W(2)) dut_w2 (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid), .err_clr(err_clr),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2),
    .zero_det(zero_det2), .period_mark(period_mark2)
  );

  task automatic send(input logic [3:0] d, input logic v);
    din = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq();
    send(seq[idx], 1'b1);
    idx = (idx + 1) % 15;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    send(4'h8, 1'b1);
    send(4'h1, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_locked got=%b exp=0", locked); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_err_count got=%0d exp=0", err_count); end
    n_cmp++; if ({err_pulse, zero_det, period_mark} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_pulses got=%b exp=000", {err_pulse, zero_det, period_mark}); end
    clear = 1'b1;
  endtask

  task automatic test_clean_lock();
    idx = 0;
    repeat (3) send_seq();
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_early got=%b exp=0", locked); end
    send_seq();
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL lock_4th got=%b exp=1", locked); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL lock_err_count got=%0d exp=0", err_count); end
    for (int i = 0; i < 11; i++) begin
      send_seq();
      n_cmp++; if (period_mark !== 1'b0) begin n_fail++; $display("[TB] FAIL period_early i=%0d got=%b exp=0", i, period_mark); end
    end
    send_seq();
    n_cmp++; if (period_mark !== 1'b1) begin n_fail++; $display("[TB] FAIL period_mark got=%b exp=1", period_mark); end
    send_seq();
    n_cmp++; if (period_mark !== 1'b0) begin n_fail++; $display("[TB] FAIL period_width got=%b exp=0", period_mark); end
  endtask

  task automatic test_single_error();
    send_seq();
    send_seq();
    send(4'hB, 1'b1);
    idx = 5;
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL single_err_pulse got=%b exp=1", err_pulse); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("[TB] FAIL single_err_count got=%0d exp=1", err_count); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL single_locked got=%b exp=1", locked); end
    send_seq();
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL flywheel_pulse got=%b exp=0", err_pulse); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("[TB] FAIL flywheel_count got=%0d exp=1", err_count); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL flywheel_locked got=%b exp=1", locked); end
  endtask

  task automatic test_lock_loss();
    err_clr = 1'b1;
    send(4'h0, 1'b0);
    err_clr = 1'b0;
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL errclr_idle got=%0d exp=0", err_count); end
    send(4'h5, 1'b1);
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_pulse1 got=%b exp=1", err_pulse); end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_locked1 got=%b exp=1", locked); end
    send(4'h5, 1'b1);
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL loss_pulse2 got=%b exp=1", err_pulse); end
    n_cmp++; if (err_count !== 16'd2) begin n_fail++; $display("[TB] FAIL loss_count got=%0d exp=2", err_count); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL loss_locked2 got=%b exp=0", locked); end
    idx = 8;
    repeat (3) send_seq();
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL reacq_early got=%b exp=0", locked); end
    send_seq();
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL reacq_locked got=%b exp=1", locked); end
    n_cmp++; if (err_count !== 16'd2) begin n_fail++; $display("[TB] FAIL reacq_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_zero();
    clear = 1'b0;
    send(4'h0, 1'b0);
    clear = 1'b1;
    send(4'h0, 1'b1);
    n_cmp++; if (zero_det !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_hunt got=%b exp=1", zero_det); end
    send(4'h0, 1'b1);
    n_cmp++; if (zero_det !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_hunt_b2b got=%b exp=1", zero_det); end
    send(4'h8, 1'b1);
    n_cmp++; if (zero_det !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_clear got=%b exp=0", zero_det); end
    send(4'h0, 1'b1);
    n_cmp++; if (zero_det !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_sync got=%b exp=1", zero_det); end
    n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_sync_err got=%b exp=0", err_pulse); end
    idx = 2;
    repeat (3) send_seq();
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_relock_early got=%b exp=0", locked); end
    send_seq();
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_relock got=%b exp=1", locked); end
    send(4'h0, 1'b1);
    idx = 7;
    n_cmp++; if (zero_det !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_locked got=%b exp=1", zero_det); end
    n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_locked_err got=%b exp=1", err_pulse); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("[TB] FAIL zero_locked_count got=%0d exp=1", err_count); end
    send_seq();
    n_cmp++; if ({zero_det, err_pulse, locked} !== 3'b001) begin n_fail++; $display("[TB] FAIL zero_after got=%b exp=001", {zero_det, err_pulse, locked}); end
  endtask

  task automatic test_valid_gaps();
    for (int i = 0; i < 6; i++) begin
      send_seq();
      n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_valid i=%0d got=%b exp=0", i, err_pulse); end
      send(4'h0, 1'b0);
      n_cmp++; if (zero_det !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_zero i=%0d got=%b exp=0", i, zero_det); end
      send(4'h3, 1'b0);
      n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL gap_invalid i=%0d got=%b exp=0", i, err_pulse); end
    end
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL gap_locked got=%b exp=1", locked); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("[TB] FAIL gap_count got=%0d exp=1", err_count); end
  endtask

  task automatic test_counter_edges();
    logic [1:0] exp2;
    err_clr = 1'b1;
    send(4'h0, 1'b0);
    err_clr = 1'b0;
    n_cmp++; if (err_count2 !== 2'd0) begin n_fail++; $display("[TB] FAIL sat_clear got=%0d exp=0", err_count2); end
    for (int k = 1; k <= 5; k++) begin
      send(seq[idx] ^ 4'h1, 1'b1);
      idx = (idx + 1) % 15;
      exp2 = (k > 3) ? 2'd3 : 2'(k);
      n_cmp++; if (err_count2 !== exp2) begin n_fail++; $display("[TB] FAIL sat_count k=%0d got=%0d exp=%0d", k, err_count2, exp2); end
      send_seq();
    end
    n_cmp++; if (err_count !== 16'd5) begin n_fail++; $display("[TB] FAIL wide_count got=%0d exp=5", err_count); end
    n_cmp++; if (locked2 !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_locked got=%b exp=1", locked2); end
    err_clr = 1'b1;
    send(seq[idx] ^ 4'h1, 1'b1);
    idx = (idx + 1) % 15;
    err_clr = 1'b0;
    n_cmp++; if (err_count2 !== 2'd1) begin n_fail++; $display("[TB] FAIL clr_coincident got=%0d exp=1", err_count2); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("[TB] FAIL clr_coincident_wide got=%0d exp=1", err_count); end
    send_seq();
  endtask

  task automatic test_clear_mid_locked();
    n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_clear_locked got=%b exp=1", locked); end
    clear = 1'b0;
    send(4'h0, 1'b1);
    n_cmp++; if ({locked, err_pulse, zero_det, period_mark} !== 4'b0000) begin n_fail++; $display("[TB] FAIL clear_outputs got=%b exp=0000", {locked, err_pulse, zero_det, period_mark}); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL clear_count got=%0d exp=0", err_count); end
    n_cmp++; if ({locked2, err_count2} !== 3'b000) begin n_fail++; $display("[TB] FAIL clear_w2 got=%b exp=000", {locked2, err_count2}); end
    clear = 1'b1;
    send(4'h8, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_hunt got=%b exp=0", locked); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_lock_loss();
    test_zero();
    test_valid_gaps();
    test_counter_edges();
    test_clear_mid_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
